// File: rtl/msrv32_rf_write_arbiter.sv
// msrv32_rf_write_arbiter: round-robin share of the register file write port plus a pending-write scoreboard.
module msrv32_rf_write_arbiter (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   input  logic        req0_valid_in,
   input  logic [4:0]  req0_addr_in,
   input  logic [31:0] req0_data_in,
   output logic        req0_ready_out,
   input  logic        req1_valid_in,
   input  logic [4:0]  req1_addr_in,
   input  logic [31:0] req1_data_in,
   output logic        req1_ready_out,
   input  logic        issue_en_in,
   input  logic [4:0]  issue_rd_in,
   input  logic        flush_in,
   input  logic [4:0]  rs1_addr_in,
   input  logic [4:0]  rs2_addr_in,
   output logic        rs1_busy_out,
   output logic        rs2_busy_out,
   output logic        wr_en_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_out
);
   logic        pri;
   logic [31:1] busy_q;
   logic [31:1] busy_nxt;
   logic [31:0] busy;
   logic        acc;
   logic [4:0]  acc_addr;
   logic [31:0] acc_data;
   always_comb begin
      req0_ready_out = ms_riscv32_mp_rst_n_in && req0_valid_in && (!req1_valid_in || !pri);
      req1_ready_out = ms_riscv32_mp_rst_n_in && req1_valid_in && (!req0_valid_in || pri);
      acc      = req0_ready_out || req1_ready_out;
      acc_addr = req1_ready_out ? req1_addr_in : req0_addr_in;
      acc_data = req1_ready_out ? req1_data_in : req0_data_in;
      busy     = {busy_q, 1'b0};
      rs1_busy_out = busy[rs1_addr_in];
      rs2_busy_out = busy[rs2_addr_in];
      // a new producer's set overrides both the flush and a same-cycle clear
      for (int i = 1; i < 32; i++)
         busy_nxt[i] = (issue_en_in && issue_rd_in == 5'(i)) ||
                       (!flush_in && busy_q[i] && !(acc && acc_addr == 5'(i)));
   end
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         pri         <= 1'b0;
         busy_q      <= '0;
         wr_en_out   <= 1'b0;
         rd_addr_out <= '0;
         rd_out      <= '0;
      end else begin
         pri       <= req0_ready_out ? 1'b1 : req1_ready_out ? 1'b0 : pri;
         busy_q    <= busy_nxt;
         wr_en_out <= acc && |acc_addr;
         if (acc) begin
            rd_addr_out <= acc_addr;
            rd_out      <= acc_data;
         end
      end
   end
endmodule
